// File: rtl/rv_pkg.sv
// Shared pipeline definitions: opcode constants, the tracked stage entry and
// the opcode-class helpers used by the hazard scoreboard.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    // Widest register index an entry can hold; narrower indices are zero-extended.
    localparam int unsigned REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  load;
    } stage_entry_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op[6] & ~op[3]) | ~op[2];
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return !((op == OP_STORE) || (op == OP_BRANCH));
    endfunction

    function automatic logic is_load(input logic [6:0] op);
        return op == OP_LOAD;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: decode slot, pipe control and
// the stall/forward/counter results.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned IDX_W = $clog2(DEPTH + 1);

    logic              id_valid;
    logic [6:0]        id_op;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              hold;
    logic              flush;
    logic              stall;
    logic [IDX_W-1:0]  fwd_rs1;
    logic [IDX_W-1:0]  fwd_rs2;
    logic [CNT_W-1:0]  stall_cnt;

    // Decode / pipeline control side
    modport master (
        output id_valid, id_op, id_rs1, id_rs2, id_rd, hold, flush,
        input  stall, fwd_rs1, fwd_rs2, stall_cnt
    );

    // Scoreboard side
    modport slave (
        input  id_valid, id_op, id_rs1, id_rs2, id_rd, hold, flush,
        output stall, fwd_rs1, fwd_rs2, stall_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// Per-source comparator: finds the youngest tracked entry writing the source
// register and decides whether it can be forwarded or must stall decode.
module hazard_match
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 1,
    parameter int unsigned FWD_EN     = 1,
    parameter int unsigned IDX_W      = 2
) (
    input  stage_entry_t [DEPTH-1:0] entries,
    input  logic [REG_AW_MAX-1:0]    src,
    input  logic                     use_src,
    output logic [IDX_W-1:0]         win,
    output logic                     hazard
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        win    = '0;
        hazard = 1'b0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (use_src && entries[k].valid && (entries[k].rd != '0) &&
                (entries[k].rd == src)) begin
                win    = IDX_W'(k + 1);
                hazard = (FWD_EN == 0) || (entries[k].load && (k < int'(LOAD_READY)));
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit: tracks destination registers of in-flight instructions past
// decode, checks both sources of the decoding instruction, and produces the
// decode stall, forwarding selects and a saturating hazard-stall counter.
module hazard_scoreboard
    import rv_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 1,
    parameter int unsigned FWD_EN     = 1,
    parameter int unsigned CNT_W      = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH + 1);

    stage_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [CNT_W-1:0]         cnt_q;

    logic                  use1, use2, id_wr, id_load;
    logic [REG_AW_MAX-1:0] rs1_x, rs2_x, rd_x;
    logic [IDX_W-1:0]      win1, win2;
    logic                  haz1, haz2, haz_any, stall, insert, cnt_inc;

    assign use1    = uses_rs1(bus.id_op);
    assign use2    = uses_rs2(bus.id_op);
    assign id_wr   = writes_rd(bus.id_op);
    assign id_load = is_load(bus.id_op);
    assign rs1_x   = REG_AW_MAX'(bus.id_rs1);
    assign rs2_x   = REG_AW_MAX'(bus.id_rs2);
    assign rd_x    = REG_AW_MAX'(bus.id_rd);

    hazard_match #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .FWD_EN     (FWD_EN),
        .IDX_W      (IDX_W)
    ) u_match_rs1 (
        .entries (ent_q),
        .src     (rs1_x),
        .use_src (use1),
        .win     (win1),
        .hazard  (haz1)
    );

    hazard_match #(
        .DEPTH      (DEPTH),
        .LOAD_READY (LOAD_READY),
        .FWD_EN     (FWD_EN),
        .IDX_W      (IDX_W)
    ) u_match_rs2 (
        .entries (ent_q),
        .src     (rs2_x),
        .use_src (use2),
        .win     (win2),
        .hazard  (haz2)
    );

    assign haz_any = bus.id_valid & (haz1 | haz2);
    assign stall   = bus.hold | haz_any;
    assign insert  = bus.id_valid & ~stall & id_wr;
    // Stalls caused by hold or cancelled by flush are not hazard stalls.
    assign cnt_inc = haz_any & ~bus.hold & ~bus.flush;

    assign bus.stall     = stall;
    assign bus.fwd_rs1   = (stall | haz1) ? '0 : win1;
    assign bus.fwd_rs2   = (stall | haz2) ? '0 : win2;
    assign bus.stall_cnt = cnt_q;

    // Next entries: flush clears, hold freezes, otherwise shift and insert/bubble.
    always_comb begin
        ent_d = ent_q;
        if (bus.flush) begin
            ent_d = '0;
        end else if (!bus.hold) begin
            for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                ent_d[k] = ent_q[k-1];
            end
            ent_d[0] = '0;
            if (insert) begin
                ent_d[0].valid = 1'b1;
                ent_d[0].rd    = rd_x;
                ent_d[0].load  = id_load;
            end
        end
    end

    // Entry shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    // Saturating hazard-stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (default, no forwarding, 2-bit
// counter) share one stimulus stream; a reference model predicts every cycle.
module tb_hazard_scoreboard;
    localparam int D = 3;
    localparam int LOAD_READY = 1;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] ADD = 7'b0110011;

    typedef struct packed {
        logic        stall;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        int    inst;
        int    field;
        int    want;
        string name;
    } dchk_t;

    logic clk;
    logic rst_n;

    hazard_scoreboard_if #(.REG_AW(5), .DEPTH(3), .CNT_W(16)) bus_a ();
    hazard_scoreboard_if #(.REG_AW(5), .DEPTH(3), .CNT_W(16)) bus_b ();
    hazard_scoreboard_if #(.REG_AW(5), .DEPTH(3), .CNT_W(2))  bus_c ();

    hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .LOAD_READY(1), .FWD_EN(1), .CNT_W(16)) u_dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a)
    );
    hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .LOAD_READY(1), .FWD_EN(0), .CNT_W(16)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b)
    );
    hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .LOAD_READY(1), .FWD_EN(1), .CNT_W(2)) u_dut_c (
        .clk (clk), .rst_n (rst_n), .bus (bus_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_cmp = 0;
    int    n_bad = 0;
    exp_t  sbq[3][$];
    dchk_t dq[$];

    // Per-instance configuration and reference state.
    bit fwd_en[3]  = '{1'b1, 1'b0, 1'b1};
    int cnt_max[3] = '{65535, 65535, 3};
    bit m_v[3][D];
    int m_rd[3][D];
    bit m_ld[3][D];
    int m_cnt[3];
    bit m_haz[3];
    bit m_stall[3];

    logic       s_valid, s_hold, s_flush;
    logic [6:0] s_op;
    int         s_rs1, s_rs2, s_rd;

    function automatic exp_t act(int i);
        exp_t a;
        case (i)
            0: a = {bus_a.stall, bus_a.fwd_rs1, bus_a.fwd_rs2, bus_a.stall_cnt};
            1: a = {bus_b.stall, bus_b.fwd_rs1, bus_b.fwd_rs2, bus_b.stall_cnt};
            default: a = {bus_c.stall, bus_c.fwd_rs1, bus_c.fwd_rs2, 14'd0, bus_c.stall_cnt};
        endcase
        return a;
    endfunction

    function automatic int field_of(exp_t a, int f);
        case (f)
            0: return int'(a.stall);
            1: return int'(a.f1);
            2: return int'(a.f2);
            default: return int'(a.cnt);
        endcase
    endfunction

    // Youngest in-flight writer of src, or -1.
    function automatic int youngest(int i, int src, bit used);
        for (int k = 0; k < D; k++)
            if (used && m_v[i][k] && m_rd[i][k] != 0 && m_rd[i][k] == src) return k;
        return -1;
    endfunction

    function automatic exp_t model_eval(int i);
        exp_t e;
        bit   u1, u2, h1, h2;
        int   w1, w2;
        u1 = (s_op[6] & ~s_op[3]) | ~s_op[2];
        u2 = s_op inside {7'b0110011, 7'b0100011, 7'b1100011};
        w1 = youngest(i, s_rs1, u1);
        w2 = youngest(i, s_rs2, u2);
        h1 = (w1 >= 0) && (!fwd_en[i] || (m_ld[i][w1 < 0 ? 0 : w1] && w1 < LOAD_READY));
        h2 = (w2 >= 0) && (!fwd_en[i] || (m_ld[i][w2 < 0 ? 0 : w2] && w2 < LOAD_READY));
        m_haz[i]   = h1 || h2;
        m_stall[i] = s_hold || (s_valid && m_haz[i]);
        e.stall = m_stall[i];
        e.f1    = (m_stall[i] || h1 || w1 < 0) ? 2'd0 : 2'(w1 + 1);
        e.f2    = (m_stall[i] || h2 || w2 < 0) ? 2'd0 : 2'(w2 + 1);
        e.cnt   = 16'(m_cnt[i]);
        return e;
    endfunction

    task automatic model_commit(int i);
        bit wr;
        wr = !(s_op inside {7'b0100011, 7'b1100011});
        if (s_valid && m_haz[i] && !s_hold && !s_flush && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        if (s_flush) begin
            for (int k = 0; k < D; k++) m_v[i][k] = 1'b0;
        end else if (!s_hold) begin
            for (int k = D - 1; k > 0; k--) begin
                m_v[i][k]  = m_v[i][k-1];
                m_rd[i][k] = m_rd[i][k-1];
                m_ld[i][k] = m_ld[i][k-1];
            end
            m_v[i][0]  = s_valid && !m_stall[i] && wr;
            m_rd[i][0] = s_rd;
            m_ld[i][0] = (s_op == LW);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            for (int k = 0; k < D; k++) m_v[i][k] = 1'b0;
        end
    endtask

    task automatic want(int inst, int field, int val, string name);
        dchk_t d;
        d.inst = inst; d.field = field; d.want = val; d.name = name;
        dq.push_back(d);
    endtask

    task automatic set_bus();
        bus_a.id_valid = s_valid; bus_a.id_op = s_op; bus_a.hold = s_hold; bus_a.flush = s_flush;
        bus_a.id_rs1 = 5'(s_rs1); bus_a.id_rs2 = 5'(s_rs2); bus_a.id_rd = 5'(s_rd);
        bus_b.id_valid = s_valid; bus_b.id_op = s_op; bus_b.hold = s_hold; bus_b.flush = s_flush;
        bus_b.id_rs1 = 5'(s_rs1); bus_b.id_rs2 = 5'(s_rs2); bus_b.id_rd = 5'(s_rd);
        bus_c.id_valid = s_valid; bus_c.id_op = s_op; bus_c.hold = s_hold; bus_c.flush = s_flush;
        bus_c.id_rs1 = 5'(s_rs1); bus_c.id_rs2 = 5'(s_rs2); bus_c.id_rd = 5'(s_rd);
    endtask

    task automatic drive(logic v, logic [6:0] op, int rs1, int rs2, int rd, logic h, logic f);
        s_valid = v; s_op = op; s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_hold = h; s_flush = f;
        set_bus();
        for (int i = 0; i < 3; i++) sbq[i].push_back(model_eval(i));
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_commit(i);
        #1;
    endtask

    task automatic idle(int n);
        for (int j = 0; j < n; j++) begin
            drive(1'b0, ADD, 0, 0, 0, 1'b0, 1'b0);
            tick();
        end
    endtask

    // Asynchronous reset pulse confined between a rising and the next falling edge.
    task automatic reset_pulse();
        s_valid = 1'b0; s_hold = 1'b0; s_flush = 1'b0; set_bus();
        rst_n = 1'b0;
        model_reset();
        want(0, 3, 0, "rst_cnt_a");
        want(2, 3, 0, "rst_cnt_c");
        want(0, 0, 0, "rst_stall_a");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every queued expectation on the falling edge.
    always @(negedge clk) begin
        exp_t  e, a;
        dchk_t d;
        int    g;
        for (int i = 0; i < 3; i++) begin
            if (sbq[i].size() != 0) begin
                e = sbq[i].pop_front();
                a = act(i);
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL sb%0d t=%0t: got stall=%0d fwd=%0d/%0d cnt=%0d, want stall=%0d fwd=%0d/%0d cnt=%0d",
                             i, $time, a.stall, a.f1, a.f2, a.cnt, e.stall, e.f1, e.f2, e.cnt);
                end
            end
        end
        while (dq.size() != 0) begin
            d = dq.pop_front();
            g = field_of(act(d.inst), d.field);
            n_cmp++;
            if (g != d.want) begin
                n_bad++;
                $display("FAIL %s (dut%0d) t=%0t: got %0d, want %0d", d.name, d.inst, $time, g, d.want);
            end
        end
    end

    logic [6:0] ops[8] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                          7'b0010011, 7'b0110111, 7'b1101111, 7'b1100111};

    initial begin
        logic [6:0] op;
        rst_n = 1'b0;
        s_valid = 1'b0; s_op = ADD; s_rs1 = 0; s_rs2 = 0; s_rd = 0; s_hold = 1'b0; s_flush = 1'b0;
        set_bus();
        model_reset();

        // Reset state: stall follows hold, no forwarding, counter clear.
        want(0, 0, 0, "reset_stall");
        want(0, 1, 0, "reset_fwd1");
        want(0, 2, 0, "reset_fwd2");
        want(0, 3, 0, "reset_cnt");
        @(negedge clk); #1;
        s_hold = 1'b1; set_bus();
        want(0, 0, 1, "reset_stall_hold");
        @(negedge clk); #1;
        s_hold = 1'b0; set_bus();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD x5 then reader of x5 forwards from EX.
        drive(1'b1, ADD, 0, 0, 5, 1'b0, 1'b0); tick();
        drive(1'b1, ADD, 5, 0, 6, 1'b0, 1'b0);
        want(0, 1, 1, "add_fwd_ex");
        want(0, 0, 0, "add_no_stall");
        want(1, 0, 1, "nofwd_stall");
        tick();
        idle(3);

        // Load-use: one stall, then forward from MEM.
        drive(1'b1, LW, 1, 0, 7, 1'b0, 1'b0); tick();
        drive(1'b1, ADD, 0, 7, 8, 1'b0, 1'b0);
        want(0, 0, 1, "lu_stall");
        want(0, 3, 0, "lu_cnt0");
        tick();
        drive(1'b1, ADD, 0, 7, 8, 1'b0, 1'b0);
        want(0, 0, 0, "lu_go");
        want(0, 2, 2, "lu_fwd_mem");
        want(0, 3, 1, "lu_cnt1");
        tick();
        idle(3);

        // x0 never matches; youngest writer wins.
        drive(1'b1, ADD, 0, 0, 0, 1'b0, 1'b0); tick();
        drive(1'b1, ADD, 0, 0, 9, 1'b0, 1'b0);
        want(0, 0, 0, "x0_stall");
        want(0, 1, 0, "x0_fwd1");
        want(0, 2, 0, "x0_fwd2");
        tick();
        idle(3);
        drive(1'b1, ADD, 0, 0, 4, 1'b0, 1'b0); tick();
        drive(1'b1, ADD, 0, 0, 11, 1'b0, 1'b0); tick();
        drive(1'b1, ADD, 0, 0, 4, 1'b0, 1'b0); tick();
        drive(1'b1, ADD, 4, 0, 12, 1'b0, 1'b0);
        want(0, 1, 1, "youngest_wins");
        tick();
        idle(3);

        // No forwarding: stall until the writer leaves the tracked stages.
        drive(1'b1, ADD, 0, 0, 3, 1'b0, 1'b0); tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, ADD, 3, 0, 13, 1'b0, 1'b0);
            want(1, 0, (c < 3) ? 1 : 0, "nofwd_stall_seq");
            want(1, 1, 0, "nofwd_fwd_zero");
            tick();
        end
        idle(3);

        // Hold freezes a load in EX without counting; flush clears it.
        drive(1'b1, LW, 0, 0, 9, 1'b0, 1'b0); tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, ADD, 9, 0, 14, 1'b1, 1'b0);
            want(0, 0, 1, "hold_stall");
            want(0, 3, 1, "hold_cnt");
            tick();
        end
        drive(1'b1, ADD, 9, 0, 14, 1'b0, 1'b1);
        want(0, 0, 1, "flush_stall");
        tick();
        drive(1'b1, ADD, 9, 0, 15, 1'b0, 1'b0);
        want(0, 0, 0, "post_flush_go");
        want(0, 1, 0, "post_flush_fwd");
        want(0, 3, 1, "post_flush_cnt");
        tick();

        // Load-use stream saturates the 2-bit counter.
        for (int p = 0; p < 5; p++) begin
            drive(1'b1, LW, 0, 0, 7, 1'b0, 1'b0); tick();
            drive(1'b1, ADD, 0, 7, 8, 1'b0, 1'b0); tick();
            drive(1'b1, ADD, 0, 7, 8, 1'b0, 1'b0); tick();
        end
        drive(1'b1, LW, 0, 0, 7, 1'b0, 1'b0); tick();
        drive(1'b1, ADD, 0, 7, 8, 1'b0, 1'b0);
        want(2, 3, 3, "sat_cnt");
        tick();
        drive(1'b1, ADD, 0, 7, 8, 1'b0, 1'b0);
        want(2, 3, 3, "sat_hold_at_max");
        tick();
        reset_pulse();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
            drive($urandom_range(0, 99) < 85, op, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5);
            tick();
            if (c == 200) reset_pulse();
        end

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard unit for the RISC-V pipeline: tracks the destination registers of up to DEPTH in-flight instructions past decode and checks both rs1 and rs2 of the decoding instruction against them. It produces a decode stall, per-source forwarding selects, and a saturating stall-cycle counter. It sits between the decode stage and the EX/MEM/WB pipeline registers and replaces the single-source rs1/rd comparator.

## Interface
- REG_AW, 5: register index width.
- DEPTH, 3: tracked stages after decode (index 0 = EX, 1 = MEM, 2 = WB).
- LOAD_READY, 1: lowest stage index from which a load result is forwardable.
- FWD_EN, 1: 1 = forward when possible, 0 = stall on every match.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- id_valid  in  1  decode slot holds a real instruction.
- id_op  in  7  opcode of the decoding instruction.
- id_rs1, id_rs2, id_rd  in  REG_AW  source and destination indices.
- hold  in  1  downstream freeze; the whole pipe stalls.
- flush  in  1  branch/trap flush of all tracked stages.
- stall  out  1  decode must not advance this cycle.
- fwd_rs1, fwd_rs2  out  $clog2(DEPTH+1)  0 = register file, k = forward from stage k-1.
- stall_cnt  out  CNT_W  hazard-stall cycles; saturates at all-ones.

## Operation
- Opcode decode:
  - uses_rs1 = (op[6] & ~op[3]) | ~op[2].
  - uses_rs2 = op ∈ {0110011, 0100011, 1100011}.
  - writes_rd = op ∉ {0100011, 1100011}.
  - is_load = (op == 0000011).
- Each stage entry holds {valid, rd, is_load}. An entry matches a source when: valid, rd ≠ 0, rd == source index, and the source is used. x0 never matches.
- Per source, the youngest (lowest-index) matching entry wins.
  - hazard_k: a winner exists and either FWD_EN == 0, or the winner is a load at index < LOAD_READY.
  - Otherwise fwd = winner index + 1, or 0 if there is no winner.
- stall = hold | (id_valid & (hazard_rs1 | hazard_rs2)).
- When stall = 1, fwd_rs1 = fwd_rs2 = 0.
- Shift on each rising edge:
  - flush = 1: all entries invalid, no insertion. Flush has priority over hold.
  - Else hold = 1: all entries frozen.
  - Else: entry[k] ← entry[k-1].
  - entry[0] ← {1, id_rd, is_load} if id_valid & ~stall & writes_rd; otherwise a bubble (valid = 0).
- stall_cnt increments when id_valid & (hazard_rs1 | hazard_rs2) & ~hold & ~flush. Hold cycles are not counted. The counter stops at 2^CNT_W−1.

## Timing
- stall and fwd_* are combinational from the registered entries and the current id_* inputs. There is no added latency and no path from id_* to an entry without passing a flop.
- A load at stage 0 (EX) causes exactly one stall cycle when LOAD_READY = 1. The next cycle forwards from MEM (fwd = 2).
- Reset (asynchronous, rst_n low): all entries invalid, stall_cnt = 0. stall = hold, fwd_* = 0. Reset mid-operation discards in-flight entries immediately.
- flush and a hazard in the same cycle: stall still asserts combinationally for that cycle, but the stall is not counted. The next cycle sees an empty pipe.

## Structure
- Shared package `rv_pkg`: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE) and the stage-entry struct.
- One sub-module, `hazard_match`, instantiated once per source. Inputs are the entries plus the source index and use flag; outputs are the winner index and the hazard flag.
- The top level holds the entry shift register, the opcode decode and the counter.

## Test plan
- Reset, then ADD x5 (op 0110011, rd = 5), then ADD with rs1 = 5 → fwd_rs1 = 1, stall = 0.
- LW x7 followed by an instruction using rs2 = 7 → one cycle with stall = 1 and stall_cnt 0→1, then fwd_rs2 = 2 with stall = 0.
- Writer to x0, then a reader of x0 → no stall, fwd = 0. The same rd written at stages 0 and 2 → youngest wins, fwd = 1.
- FWD_EN = 0: ADD x3, then a reader of x3 → stall for 3 cycles until the entry leaves DEPTH, then fwd = 0.
- LW x9 in EX with hold = 1 for 4 cycles: entries frozen and stall_cnt unchanged. Then flush → entries cleared, a reader of x9 proceeds with fwd = 0.
- CNT_W = 2 with a continuous load-use stream: counter reaches 3 and stays at 3. An rst_n pulse mid-stream clears it to 0 asynchronously.
